baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 145 ++++++++++++++
 tb/tb_baud_gen_frac.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample, mid-bit and bit ticks from an
// integer + fractional divisor, with a shadow config applied on bit boundaries.
module baud_gen_frac #(
  parameter int unsigned DIV_W            = 16,
  parameter int unsigned FRAC_W           = 4,
  parameter int unsigned DEFAULT_DIV_INT  = 27,
  parameter int unsigned DEFAULT_DIV_FRAC = 2,
  parameter bit          DEFAULT_OSR8     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              osr8,
  input  logic              cfg_load,
  input  logic              resync,
  output logic              oversample_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              cfg_pending
);

  localparam int unsigned CW   = DIV_W + 1;
  localparam int unsigned OS_W = 4;

  logic [DIV_W-1:0]  a_int_q,  a_int_d,  s_int_q,  s_int_d;
  logic [FRAC_W-1:0] a_frac_q, a_frac_d, s_frac_q, s_frac_d;
  logic              a_osr8_q, a_osr8_d, s_osr8_q, s_osr8_d;
  logic              pending_q, pending_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic              ov_q, ov_d, bit_q, bit_d, mid_q, mid_d;

  logic [DIV_W-1:0]  eff_int;
  logic [CW-1:0]     p_m1;
  logic [FRAC_W:0]   acc_sum;
  logic [OS_W-1:0]   os_last, os_mid;
  logic              at_last;
  logic              xfer;

  // Divisors below 2 cannot produce distinct tick cycles, so clamp them.
  assign eff_int = (a_int_q < DIV_W'(2)) ? DIV_W'(2) : a_int_q;
  assign p_m1    = {1'b0, eff_int} + CW'(extra_q) - CW'(1);
  assign acc_sum = {1'b0, acc_q} + {1'b0, a_frac_q};
  assign os_last = a_osr8_q ? OS_W'(7) : OS_W'(15);
  assign os_mid  = a_osr8_q ? OS_W'(3) : OS_W'(7);
  assign at_last = (os_q == os_last);

  always_comb begin
    a_int_d   = a_int_q;
    a_frac_d  = a_frac_q;
    a_osr8_d  = a_osr8_q;
    s_int_d   = s_int_q;
    s_frac_d  = s_frac_q;
    s_osr8_d  = s_osr8_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    extra_d   = extra_q;
    os_d      = os_q;
    ov_d      = 1'b0;
    bit_d     = 1'b0;
    mid_d     = 1'b0;
    xfer      = 1'b0;

    if (cfg_load) begin
      s_int_d  = div_int;
      s_frac_d = div_frac;
      s_osr8_d = osr8;
    end

    if (resync) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      os_d    = '0;
    end else if (!enable) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      os_d    = '0;
      xfer    = pending_q;
    end else if (cnt_q == p_m1) begin
      cnt_d            = '0;
      {extra_d, acc_d} = acc_sum;
      os_d             = at_last ? '0 : os_q + OS_W'(1);
      ov_d             = 1'b1;
      bit_d            = at_last;
      mid_d            = (os_q == os_mid);
      xfer             = at_last & pending_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // The old shadow moves to active before a coincident capture overwrites it.
    if (xfer) begin
      a_int_d  = s_int_q;
      a_frac_d = s_frac_q;
      a_osr8_d = s_osr8_q;
    end
    pending_d = cfg_load | (pending_q & ~xfer);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_int_q   <= DIV_W'(DEFAULT_DIV_INT);
      a_frac_q  <= FRAC_W'(DEFAULT_DIV_FRAC);
      a_osr8_q  <= DEFAULT_OSR8;
      s_int_q   <= DIV_W'(DEFAULT_DIV_INT);
      s_frac_q  <= FRAC_W'(DEFAULT_DIV_FRAC);
      s_osr8_q  <= DEFAULT_OSR8;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      extra_q   <= 1'b0;
      os_q      <= '0;
      ov_q      <= 1'b0;
      bit_q     <= 1'b0;
      mid_q     <= 1'b0;
    end else begin
      a_int_q   <= a_int_d;
      a_frac_q  <= a_frac_d;
      a_osr8_q  <= a_osr8_d;
      s_int_q   <= s_int_d;
      s_frac_q  <= s_frac_d;
      s_osr8_q  <= s_osr8_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      extra_q   <= extra_d;
      os_q      <= os_d;
      ov_q      <= ov_d;
      bit_q     <= bit_d;
      mid_q     <= mid_d;
    end
  end

  assign oversample_tick = ov_q;
  assign bit_tick        = bit_q;
  assign mid_tick        = mid_q;
  assign cfg_pending     = pending_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick spacing, fractional periods,
// shadow config transfer, resync suppression and async reset.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        osr8;
  logic        cfg_load;
  logic        resync;
  logic        oversample_tick;
  logic        bit_tick;
  logic        mid_tick;
  logic        cfg_pending;

  int errors = 0;
  int checks = 0;
  int n;

  baud_gen_frac dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .div_int         (div_int),
    .div_frac        (div_frac),
    .osr8            (osr8),
    .cfg_load        (cfg_load),
    .resync          (resync),
    .oversample_tick (oversample_tick),
    .bit_tick        (bit_tick),
    .mid_tick        (mid_tick),
    .cfg_pending     (cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the selected tick (0 = oversample, 1 = bit, 2 = mid); -1 on timeout.
  task automatic wait_tick(input int sel, output int cycles);
    logic hit;
    hit    = 1'b0;
    cycles = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step();
      cycles++;
      case (sel)
        0:       hit = oversample_tick;
        1:       hit = bit_tick;
        default: hit = mid_tick;
      endcase
    end
    if (!hit) cycles = -1;
  endtask

  task automatic load_cfg(input int di, input int df, input logic o8);
    enable   = 1'b0;
    div_int  = 16'(di);
    div_frac = 4'(df);
    osr8     = o8;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; div_int = '0; div_frac = '0; osr8 = 1'b0;
    cfg_load = 1'b0; resync = 1'b0;
    step(); step();
    check("rst_ov", int'(oversample_tick), 0);
    check("rst_bit", int'(bit_tick), 0);
    check("rst_mid", int'(mid_tick), 0);
    check("rst_pend", int'(cfg_pending), 0);
    reset = 1'b0;
    step();

    // div 4, frac 0, 16x; shadow moves to active while disabled
    div_int = 16'd4; div_frac = 4'd0; osr8 = 1'b0; cfg_load = 1'b1;
    step();
    check("ld_pend_set", int'(cfg_pending), 1);
    cfg_load = 1'b0;
    step();
    check("ld_pend_clr", int'(cfg_pending), 0);
    enable = 1'b1;
    wait_tick(0, n); check("d4_ov1", n, 4);
    wait_tick(0, n); check("d4_ov2", n, 4);
    wait_tick(2, n); check("d4_mid1", n, 24);
    wait_tick(1, n); check("d4_bit1", n, 32);
    check("d4_bit_ov", int'(oversample_tick), 1);
    check("d4_bit_mid", int'(mid_tick), 0);
    wait_tick(2, n); check("d4_mid2", n, 32);
    wait_tick(1, n); check("d4_bit2", n, 32);

    // div 4.5: intervals 4,4,5,4,5...; first bit 71, then 72
    load_cfg(4, 8, 1'b0);
    enable = 1'b1;
    wait_tick(0, n); check("fr_ov1", n, 4);
    wait_tick(0, n); check("fr_ov2", n, 4);
    wait_tick(0, n); check("fr_ov3", n, 5);
    wait_tick(0, n); check("fr_ov4", n, 4);
    wait_tick(1, n); check("fr_bit1", n, 71 - 17);
    wait_tick(1, n); check("fr_bit2", n, 72);

    // 8x oversampling, div 3
    load_cfg(3, 0, 1'b1);
    enable = 1'b1;
    wait_tick(2, n); check("o8_mid1", n, 12);
    wait_tick(1, n); check("o8_bit1", n, 12);
    wait_tick(2, n); check("o8_mid2", n, 12);
    wait_tick(1, n); check("o8_bit2", n, 12);

    // mid-bit reload to div 6 takes effect at the next bit
    load_cfg(4, 0, 1'b0);
    enable = 1'b1;
    wait_tick(2, n); check("cl_mid", n, 32);
    div_int = 16'd6; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("cl_pend_set", int'(cfg_pending), 1);
    wait_tick(1, n); check("cl_bit", n, 31);
    check("cl_pend_clr", int'(cfg_pending), 0);
    wait_tick(0, n); check("cl_ov6a", n, 6);
    wait_tick(0, n); check("cl_ov6b", n, 6);

    // resync on the edge that would emit a bit tick
    load_cfg(4, 0, 1'b0);
    enable = 1'b1;
    wait_tick(1, n); check("rs_bit0", n, 64);
    repeat (63) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rs_bit_sup", int'(bit_tick), 0);
    check("rs_ov_sup", int'(oversample_tick), 0);
    wait_tick(1, n); check("rs_bit1", n, 64);

    // async reset mid-bit with div 1 pending, then defaults and clamp
    load_cfg(4, 0, 1'b0);
    enable = 1'b1;
    wait_tick(0, n); check("ar_ov0", n, 4);
    div_int = 16'd1; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("ar_pend", int'(cfg_pending), 1);
    wait_tick(0, n); check("ar_ov1", n, 3);
    reset = 1'b1;
    #2;
    check("ar_ov_now", int'(oversample_tick), 0);
    check("ar_pend_now", int'(cfg_pending), 0);
    step();
    reset = 1'b0;
    wait_tick(0, n); check("ar_def_ov1", n, 27);
    wait_tick(0, n); check("ar_def_ov2", n, 27);
    load_cfg(1, 0, 1'b0);
    enable = 1'b1;
    wait_tick(0, n); check("clamp_ov1", n, 2);
    wait_tick(0, n); check("clamp_ov2", n, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
